bin2bcd_sum: RTL and testbench
==============================

Name: bin2bcd_sum

Overview:
- Downstream stage of the battery adder.
- Takes the 9-bit battery sum (0..511) and converts it to three BCD digits for the seven-segment display stage.
- Uses iterative shift-add-3 (double dabble), one input bit per clock.
- Valid/ready handshake on both sides, so the adder result can be presented at any time and the display stage can stall.

Parameters:
- WIDTH, 9: binary input width; must satisfy 2^WIDTH-1 <= 10^DIGITS-1.
- DIGITS, 3: number of BCD output digits.
- UMBRAL, 100: low-battery threshold. Used only when LOW_BAT_ALARM_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bin holds a sum to convert.
- in_ready  output  1  block can accept a new sum.
- bin  input  WIDTH  binary sum from adder (sum[8:0]).
- out_valid  output  1  bcd holds a finished result.
- out_ready  input  1  consumer accepts bcd.
- bcd  output  4*DIGITS  digits; [3:0] units, [7:4] tens, [11:8] hundreds.
- low_bat  output  1  present only with LOW_BAT_ALARM_EN.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, bcd=0, shift register=0, bit counter=0, low_bat=0.
- Reset assertion mid-conversion or while in DONE aborts immediately; the result is discarded and no out_valid pulse occurs.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready (cycle T): capture bin into shift register, clear BCD scratch, load counter=WIDTH, go to CONV.
  - CONV: in_ready=0. Each cycle, every scratch digit >=5 gets +3 (digits adjusted in parallel, same cycle). Then {scratch,shift} shifts left by 1 and the counter decrements. When counter reaches 0 after the WIDTH-th shift, register scratch into bcd and go to DONE.
  - DONE: out_valid=1, bcd stable, in_ready=0. On out_valid&out_ready go to IDLE.
- Latency: accept at cycle T; out_valid first high at T+WIDTH+1 (T+10 with defaults).
- Throughput: one result per WIDTH+2 cycles minimum. No accept is possible in the same cycle as the output handshake; in_ready rises the cycle after.
- bcd holds its last value after the handshake, until the next conversion completes.
- in_valid during CONV/DONE is ignored; the upstream must hold its data until in_ready.
- Arithmetic: +3 on 4-bit digits only, no carry between digits. Each digit is always 0..9 at the output.
- Boundary values: bin=0 gives bcd=000; bin=511 gives bcd=5,1,1. Values are never out of range given the parameter constraint.
- Simultaneous out_ready held high: DONE lasts exactly one cycle.

Optional Feature:
- Macro: LOW_BAT_ALARM_EN.
- Defined:
  - low_bat port exists.
  - low_bat is registered at the CONV->DONE transition as (captured bin < UMBRAL).
  - low_bat is held with bcd and reset to 0.
- Undefined: port absent, no comparator, no extra register; all other behaviour identical.

Decomposition:
- Package bin2bcd_pkg:
  - state typedef {IDLE, CONV, DONE};
  - DIGIT_W=4, ADJ_LIMIT=5, ADJ_ADD=3 constants;
  - counter width function clog2(WIDTH+1).
- Sub-module bcd_add3: combinational single-digit adjust (in >=5 ? in+3 : in), instantiated DIGITS times by generate.
- FSM, counter and shift register stay in bin2bcd_sum.

Test Plan:
- Reset then bin=0, in_valid pulse -> out_valid at T+10, bcd=0x000, in_ready returns 1 the cycle after handshake.
- bin=511 -> bcd=0x511; bin=255 -> 0x255; bin=100 -> 0x100; bin=9 -> 0x009. Sweep all 0..511 against a reference model.
- Backpressure: bin=347, out_ready low 6 cycles -> out_valid and bcd=0x347 stable all 6 cycles. in_valid with bin=12 during the stall is ignored; in_ready stays 0.
- Reset mid-conversion: assert rst_n=0 at T+4 -> out_valid=0 and bcd=0 immediately. After release, bin=42 converts to 0x042 normally.
- Back-to-back: in_valid and out_ready held high with bins 1, 2, 3 -> results 0x001, 0x002, 0x003, spaced exactly WIDTH+2 cycles apart.
- With LOW_BAT_ALARM_EN, UMBRAL=100:
  - bin=99 -> low_bat=1 with bcd=0x099;
  - bin=100 -> low_bat=0;
  - reset -> low_bat=0.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the bin2bcd_sum double-dabble converter.
// The optional LOW_BAT_ALARM_EN feature needs nothing extra from this package.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] ADJ_LIMIT = 4'd5;
    localparam logic [3:0] ADJ_ADD   = 4'd3;

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit pre-shift correction: digits of 5 or more get +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= ADJ_LIMIT) ? digit + ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_sum.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock) with
// valid/ready on both sides. Define LOW_BAT_ALARM_EN to add the low_bat flag.
module bin2bcd_sum
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
`ifdef LOW_BAT_ALARM_EN
    ,
    parameter int UMBRAL = 100
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef LOW_BAT_ALARM_EN
    ,
    output logic                      low_bat
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               last_shift;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   next_shift;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   next_scratch;
    logic [CNT_W-1:0]   cnt_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (scratch_q[i*DIGIT_W +: DIGIT_W]),
            .adjusted (adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // The adjusted scratch and the binary shift register move left as one
    // long word; the MSB of the binary part enters the units digit.
    assign next_scratch = (adj << 1) | {{(BCD_W-1){1'b0}}, shift_q[WIDTH-1]};
    assign next_shift   = shift_q << 1;
    assign last_shift   = (state_q == CONV) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bcd is only rewritten on the final shift, so it holds across handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd       <= '0;
        end else if (accept) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(WIDTH);
        end else if (state_q == CONV) begin
            shift_q   <= next_shift;
            scratch_q <= next_scratch;
            cnt_q     <= cnt_q - 1'b1;
            if (last_shift) begin
                bcd <= next_scratch;
            end
        end
    end

`ifdef LOW_BAT_ALARM_EN
    localparam logic [WIDTH:0] THRESH = (WIDTH+1)'(UMBRAL);

    logic low_pend;

    // The comparison is taken on the captured sum and only published with bcd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_pend <= 1'b0;
            low_bat  <= 1'b0;
        end else begin
            if (accept) begin
                low_pend <= ({1'b0, bin} < THRESH);
            end
            if (last_shift) begin
                low_bat <= low_pend;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_sum.sv
// Self-checking bench for bin2bcd_sum against a decimal-arithmetic reference.
// Build with LOW_BAT_ALARM_EN defined to also check the low_bat flag.
module tb_bin2bcd_sum;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;
    localparam int UMBRAL = 100;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
`ifdef LOW_BAT_ALARM_EN
    logic                  low_bat;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_sum #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
`ifdef LOW_BAT_ALARM_EN
        ,
        .low_bat   (low_bat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by division, packed four bits per digit.
    function automatic logic [31:0] refBcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r = r | (32'(x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction: present, wait for result, optionally stall, handshake.
    task automatic applyStimulus(input int val, input int stall);
        int lat;
        bin      = WIDTH'(val);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, WIDTH);
        checkOutput("bcd", bcd, refBcd(val));
`ifdef LOW_BAT_ALARM_EN
        checkOutput("low_bat", low_bat, (val < UMBRAL) ? 1 : 0);
`endif
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                in_valid = 1'b1;
                bin      = WIDTH'(12);
            end
            @(posedge clk); #1;
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_bcd", bcd, refBcd(val));
            checkOutput("stall_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("after_hs_valid", out_valid, 0);
        checkOutput("after_hs_ready", in_ready, 1);
        checkOutput("hold_bcd", bcd, refBcd(val));
    endtask

    initial begin
        int seen;
        int got;
        int sent;
        int cyc;
        int last;
        logic rdy;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;
        #23;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_bcd", bcd, 0);
`ifdef LOW_BAT_ALARM_EN
        checkOutput("rst_low_bat", low_bat, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 0);
        applyStimulus(511, 0);
        applyStimulus(255, 1);
        applyStimulus(100, 0);
        applyStimulus(9, 2);
        applyStimulus(99, 0);
        applyStimulus(347, 6);

        // Abort in the middle of a conversion.
        bin      = WIDTH'(300);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_bcd", bcd, 0);
        checkOutput("abort_in_ready", in_ready, 1);
`ifdef LOW_BAT_ALARM_EN
        checkOutput("abort_low_bat", low_bat, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("abort_no_pulse", seen, 0);
        applyStimulus(42, 0);

        // Back-to-back with the consumer always ready.
        bin       = WIDTH'(1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        got  = 0;
        sent = 0;
        cyc  = 0;
        last = 0;
        while (got < 3 && cyc < 100) begin
            rdy = in_ready;
            if (out_valid) begin
                checkOutput("b2b_bcd", bcd, refBcd(got + 1));
                if (got > 0) checkOutput("b2b_gap", cyc - last, WIDTH + 2);
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (rdy && in_valid) begin
                sent++;
                if (sent < 3) bin = WIDTH'(sent + 1);
                else in_valid = 1'b0;
            end
        end
        checkOutput("b2b_count", got, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < (1 << WIDTH); v++) begin
            applyStimulus(v, int'($urandom_range(0, 2)));
        end
        repeat (40) begin
            applyStimulus(int'($urandom_range(0, (1 << WIDTH) - 1)), int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
